// File: rtl/div_arbiter.sv
`default_nettype none
// ============================================================================
// div_arbiter : round-robin front end sharing one div_unit between two ports
// Rev 1.0
// ============================================================================
`ifndef XLEN
`define XLEN 32
`endif

module div_arbiter #(
    parameter int XLEN  = `XLEN,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,

    input  logic             req_valid_0,
    output logic             req_ready_0,
    input  logic [1:0]       req_op_0,
    input  logic             req_word_0,
    input  logic [XLEN-1:0]  req_a_0,
    input  logic [XLEN-1:0]  req_b_0,
    input  logic [TAG_W-1:0] req_tag_0,
    input  logic             kill_0,
    output logic             resp_valid_0,
    input  logic             resp_ready_0,
    output logic [XLEN-1:0]  resp_result_0,
    output logic [TAG_W-1:0] resp_tag_0,

    input  logic             req_valid_1,
    output logic             req_ready_1,
    input  logic [1:0]       req_op_1,
    input  logic             req_word_1,
    input  logic [XLEN-1:0]  req_a_1,
    input  logic [XLEN-1:0]  req_b_1,
    input  logic [TAG_W-1:0] req_tag_1,
    input  logic             kill_1,
    output logic             resp_valid_1,
    input  logic             resp_ready_1,
    output logic [XLEN-1:0]  resp_result_1,
    output logic [TAG_W-1:0] resp_tag_1,

    output logic             div_start,
    output logic [1:0]       div_op,
    output logic             div_word,
    output logic [XLEN-1:0]  div_dividend,
    output logic [XLEN-1:0]  div_divisor,
    input  logic [XLEN-1:0]  div_result,
    input  logic             div_busy,
    input  logic             div_ready
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t           state_q;
    logic             owner_q;
    logic             drop_q;
    logic             last_grant_q;
    logic [1:0]       op_q;
    logic             word_q;
    logic [XLEN-1:0]  a_q;
    logic [XLEN-1:0]  b_q;
    logic [TAG_W-1:0] tag_q;
    logic [XLEN-1:0]  result_q;

    logic [1:0] elig;
    logic       win;
    logic       accept;
    logic       kill_owner;
    logic       resp_ready_owner;
    logic       deliver;

    // A port being killed in IDLE is treated as not requesting this cycle.
    assign elig = {req_valid_1 & ~kill_1, req_valid_0 & ~kill_0};

    always_comb begin
        win = 1'b0;
        unique case (elig)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last_grant_q;
            default: win = 1'b0;
        endcase
    end

    assign accept           = reset_n && (state_q == S_IDLE) && (elig != 2'b00);
    assign req_ready_0      = accept & ~win;
    assign req_ready_1      = accept & win;

    assign kill_owner       = owner_q ? kill_1 : kill_0;
    assign resp_ready_owner = owner_q ? resp_ready_1 : resp_ready_0;

    // A kill in RESP withdraws the result in the same cycle.
    assign deliver          = (state_q == S_RESP) && !kill_owner;
    assign resp_valid_0     = deliver && !owner_q;
    assign resp_valid_1     = deliver &&  owner_q;
    assign resp_result_0    = result_q;
    assign resp_result_1    = result_q;
    assign resp_tag_0       = tag_q;
    assign resp_tag_1       = tag_q;

    assign div_start        = (state_q == S_LAUNCH) && !div_busy;
    assign div_op           = op_q;
    assign div_word         = word_q;
    assign div_dividend     = a_q;
    assign div_divisor      = b_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            drop_q       <= 1'b0;
            last_grant_q <= 1'b1;
            op_q         <= 2'b00;
            word_q       <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            tag_q        <= '0;
            result_q     <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q         <= win ? req_op_1   : req_op_0;
                        word_q       <= win ? req_word_1 : req_word_0;
                        a_q          <= win ? req_a_1    : req_a_0;
                        b_q          <= win ? req_b_1    : req_b_0;
                        tag_q        <= win ? req_tag_1  : req_tag_0;
                        owner_q      <= win;
                        last_grant_q <= win;
                        drop_q       <= 1'b0;
                        state_q      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (kill_owner) begin
                        drop_q <= 1'b1;
                    end
                    if (!div_busy) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (kill_owner) begin
                        drop_q <= 1'b1;
                    end
                    // A kill arriving with div_ready still discards the result.
                    if (div_ready) begin
                        result_q <= div_result;
                        state_q  <= (drop_q || kill_owner) ? S_IDLE : S_RESP;
                    end
                end
                S_RESP: begin
                    if (kill_owner || resp_ready_owner) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_arbiter.sv
`default_nettype none
// ============================================================================
// tb_div_arbiter : directed and random checks of div_arbiter
// Rev 1.0
// ============================================================================
module tb_div_arbiter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rv = '0, kl = '0, rr = '0, wd = '0;
    logic [1:0]  op [2];
    logic [31:0] a [2];
    logic [31:0] b [2];
    logic [4:0]  tg [2];

    logic        req_ready_0, req_ready_1, resp_valid_0, resp_valid_1;
    logic [31:0] resp_result_0, resp_result_1;
    logic [4:0]  resp_tag_0, resp_tag_1;
    logic        div_start, div_word, div_busy, div_ready;
    logic [1:0]  div_op;
    logic [31:0] div_dividend, div_divisor, div_result;

    div_arbiter #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid_0(rv[0]), .req_ready_0(req_ready_0), .req_op_0(op[0]), .req_word_0(wd[0]),
        .req_a_0(a[0]), .req_b_0(b[0]), .req_tag_0(tg[0]), .kill_0(kl[0]),
        .resp_valid_0(resp_valid_0), .resp_ready_0(rr[0]), .resp_result_0(resp_result_0), .resp_tag_0(resp_tag_0),
        .req_valid_1(rv[1]), .req_ready_1(req_ready_1), .req_op_1(op[1]), .req_word_1(wd[1]),
        .req_a_1(a[1]), .req_b_1(b[1]), .req_tag_1(tg[1]), .kill_1(kl[1]),
        .resp_valid_1(resp_valid_1), .resp_ready_1(rr[1]), .resp_result_1(resp_result_1), .resp_tag_1(resp_tag_1),
        .div_start(div_start), .div_op(div_op), .div_word(div_word),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_result(div_result), .div_busy(div_busy), .div_ready(div_ready)
    );

    // RISC-V M-extension divide/remainder semantics, 32-bit.
    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int  sx, sy;
        logic ovf;
        sx  = x;
        sy  = y;
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (o)
            2'd0:    return (y == 0) ? 32'hFFFF_FFFF : (ovf ? x : 32'(sx / sy));
            2'd1:    return (y == 0) ? 32'hFFFF_FFFF : x / y;
            2'd2:    return (y == 0) ? x : (ovf ? 32'd0 : 32'(sx % sy));
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    // Divider model: latency lat from start to a one-cycle ready pulse; dividend read at the end.
    int unsigned lat = 2, m_cnt;
    logic        m_busy, force_busy = 1'b0;
    assign div_busy = m_busy | force_busy;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 1'b0; div_ready <= 1'b0; m_cnt <= 0; div_result <= '0;
        end else begin
            div_ready <= 1'b0;
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    div_ready <= 1'b1; m_busy <= 1'b0;
                    div_result <= ref_div(div_op, div_dividend, div_divisor);
                end
            end else if (div_start) begin
                if (lat <= 1) begin
                    div_ready <= 1'b1;
                    div_result <= ref_div(div_op, div_dividend, div_divisor);
                end else begin
                    m_busy <= 1'b1; m_cnt <= lat - 1;
                end
            end
        end
    end

    int n_cmp = 0, n_bad = 0, n_starts = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_cmp++;
        n_bad++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    // Transaction-level reference: one op in flight, round-robin on ties.
    logic        m_out, m_own, m_drop, m_started, m_deliv, m_last;
    logic [1:0]  m_op;
    logic        m_wd;
    logic [31:0] m_a, m_b, m_res;
    logic [4:0]  m_tag;

    task automatic reset_model();
        m_out = 0; m_own = 0; m_drop = 0; m_started = 0; m_deliv = 0; m_last = 1;
    endtask

    logic [1:0]  s_rdy, s_rv;
    logic [31:0] s_res [2];
    logic [4:0]  s_tag [2];
    logic        s_start, s_rdyd;
    logic [31:0] s_dvd;

    // Sample the current cycle, check it against the model, then advance one clock.
    task automatic cycle();
        logic [1:0] elig, exp_rdy, exp_rv;
        logic       exp_start;
        #1;
        s_rdy = {req_ready_1, req_ready_0};
        s_rv  = {resp_valid_1, resp_valid_0};
        s_res[0] = resp_result_0; s_res[1] = resp_result_1;
        s_tag[0] = resp_tag_0;    s_tag[1] = resp_tag_1;
        s_start = div_start; s_rdyd = div_ready; s_dvd = div_dividend;
        if (s_start) n_starts++;

        elig    = rv & ~kl;
        exp_rdy = 2'b00;
        if (!m_out && elig != 2'b00)
            exp_rdy = (elig == 2'b11) ? (m_last ? 2'b01 : 2'b10) : elig;
        chk("grant", s_rdy, exp_rdy);

        exp_rv = 2'b00;
        if (m_out && m_deliv && !kl[m_own]) exp_rv[m_own] = 1'b1;
        chk("resp_valid", s_rv, exp_rv);
        if (exp_rv != 2'b00) begin
            chk("resp_result", s_res[m_own], m_res);
            chk("resp_tag", s_tag[m_own], m_tag);
        end

        exp_start = m_out && !m_started && !div_busy;
        chk("div_start", s_start, exp_start);
        if (m_out && !m_deliv) begin
            chk("div_dividend_held", div_dividend, m_a);
            chk("div_divisor_held", div_divisor, m_b);
            chk("div_op_held", div_op, m_op);
            chk("div_word_held", div_word, m_wd);
        end

        if (m_out) begin
            if (m_deliv) begin
                if (kl[m_own] || rr[m_own]) m_out = 0;
            end else begin
                if (kl[m_own]) m_drop = 1;
                if (m_started && div_ready) begin
                    if (m_drop) m_out = 0;
                    else        m_deliv = 1;
                end
                if (exp_start) m_started = 1;
            end
        end else if (exp_rdy != 2'b00) begin
            m_own = exp_rdy[1]; m_last = m_own; m_out = 1;
            m_drop = 0; m_started = 0; m_deliv = 0;
            m_op = op[m_own]; m_wd = wd[m_own]; m_a = a[m_own]; m_b = b[m_own]; m_tag = tg[m_own];
            m_res = ref_div(m_op, m_a, m_b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] t);
        op[p] = o; a[p] = x; b[p] = y; tg[p] = t; wd[p] = 1'b0; rv[p] = 1'b1;
    endtask

    task automatic wait_grant(input int p);
        logic got;
        got = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            cycle();
            got = s_rdy[p];
        end
        rv[p] = 1'b0;
        if (!got) timeout("wait_grant");
    endtask

    task automatic wait_resp(input int p);
        logic got;
        got = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            cycle();
            got = s_rv[p];
        end
        if (!got) timeout("wait_resp");
    endtask

    int          grants [4];
    int          g, n0;
    logic        seen;
    logic [31:0] rx, ry;

    initial begin
        for (int p = 0; p < 2; p++) begin op[p] = 0; a[p] = 0; b[p] = 0; tg[p] = 0; end
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        rr = 2'b11;

        // Tie arbitration: continuous requests on both ports.
        lat = 2;
        set_req(0, 2'd3, 32'd10, 32'd3, 5'd5);
        set_req(1, 2'd1, 32'd10, 32'd3, 5'd9);
        g = 0;
        for (int k = 0; k < 200 && g < 4; k++) begin
            cycle();
            if (s_rdy != 2'b00) begin grants[g] = s_rdy[1] ? 1 : 0; g++; end
            if (s_rv[0]) begin chk("t2_res0", s_res[0], 32'd1); chk("t2_tag0", s_tag[0], 5'd5); end
            if (s_rv[1]) begin chk("t2_res1", s_res[1], 32'd3); chk("t2_tag1", s_tag[1], 5'd9); end
        end
        rv = 2'b00;
        if (g < 4) timeout("t2_grants");
        else for (int i = 0; i < 4; i++) chk("t2_grant_order", grants[i], i % 2);
        for (int k = 0; k < 40 && m_out; k++) cycle();

        // Single DIV on port 0.
        lat = 3;
        set_req(0, 2'd0, 32'hFFFF_FFF9, 32'd2, 5'd3);
        wait_grant(0);
        n0 = n_starts;
        cycle();
        chk("t1_start_after_ready", s_start, 1'b1);
        wait_resp(0);
        chk("t1_result", s_res[0], 32'hFFFF_FFFD);
        chk("t1_tag", s_tag[0], 5'd3);
        chk("t1_port1_quiet", s_rv[1], 1'b0);
        chk("t1_start_pulses", n_starts - n0, 1);

        // Divide by zero REM with dividend stability.
        lat = 6;
        set_req(0, 2'd2, 32'h1234_5678, 32'd0, 5'd7);
        wait_grant(0);
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            cycle();
            chk("t3_dividend_stable", s_dvd, 32'h1234_5678);
            seen = s_rdyd;
        end
        if (!seen) timeout("t3_div_ready");
        wait_resp(0);
        chk("t3_result", s_res[0], 32'h1234_5678);

        // Kill port 1 in WAIT; port 0 is accepted right after div_ready.
        lat = 5;
        set_req(1, 2'd0, 32'd100, 32'd7, 5'd11);
        wait_grant(1);
        cycle();
        cycle();
        kl[1] = 1'b1;
        cycle();
        kl[1] = 1'b0;
        set_req(0, 2'd0, 32'd9, 32'd3, 5'd12);
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            cycle();
            chk("t4_no_resp1", s_rv[1], 1'b0);
            seen = s_rdyd;
        end
        if (!seen) timeout("t4_div_ready");
        cycle();
        chk("t4_grant_after_drop", s_rdy, 2'b01);
        rv[0] = 1'b0;
        wait_resp(0);
        chk("t4_result", s_res[0], 32'd3);

        // Back-pressure, then kill in RESP.
        lat = 2;
        rr = 2'b10;
        set_req(0, 2'd1, 32'd1000, 32'd10, 5'd13);
        wait_grant(0);
        wait_resp(0);
        set_req(1, 2'd1, 32'd50, 32'd5, 5'd14);
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk("t5_hold_valid", s_rv[0], 1'b1);
            chk("t5_hold_result", s_res[0], 32'd100);
            chk("t5_hold_tag", s_tag[0], 5'd13);
            chk("t5_no_grant", s_rdy, 2'b00);
        end
        kl[0] = 1'b1;
        rr[0] = 1'b1;
        cycle();
        chk("t5_kill_valid", s_rv[0], 1'b0);
        chk("t5_kill_no_grant", s_rdy, 2'b00);
        kl[0] = 1'b0;
        cycle();
        chk("t5_next_grant", s_rdy, 2'b10);
        rv[1] = 1'b0;
        wait_resp(1);
        chk("t5_result1", s_res[1], 32'd10);

        // Divider still busy at LAUNCH: start is deferred.
        force_busy = 1'b1;
        set_req(1, 2'd3, 32'd17, 32'd5, 5'd15);
        wait_grant(1);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("busy_no_start", s_start, 1'b0);
        end
        force_busy = 1'b0;
        cycle();
        chk("busy_start_after", s_start, 1'b1);
        wait_resp(1);
        chk("busy_result", s_res[1], 32'd2);

        // Asynchronous reset during WAIT.
        lat = 8;
        set_req(0, 2'd0, 32'd1000, 32'd3, 5'd16);
        wait_grant(0);
        cycle(); cycle(); cycle();
        set_req(0, 2'd0, 32'd1000, 32'd3, 5'd17);
        set_req(1, 2'd1, 32'd80, 32'd9, 5'd18);
        reset_n = 1'b0;
        #1;
        chk("rst_req_ready", {req_ready_1, req_ready_0}, 2'b00);
        chk("rst_resp_valid", {resp_valid_1, resp_valid_0}, 2'b00);
        chk("rst_div_start", div_start, 1'b0);
        chk("rst_div_op", {div_word, div_op}, 3'b000);
        chk("rst_dividend", div_dividend, 32'd0);
        chk("rst_divisor", div_divisor, 32'd0);
        chk("rst_result", {resp_result_1, resp_result_0}, 64'd0);
        chk("rst_tag", {resp_tag_1, resp_tag_0}, 10'd0);
        @(posedge clk); @(posedge clk);
        #1;
        reset_n = 1'b1;
        reset_model();
        cycle();
        chk("rst_tie_port0", s_rdy, 2'b01);
        rv[0] = 1'b0;
        wait_resp(0);
        chk("rst_result0", s_res[0], 32'd333);
        wait_grant(1);
        wait_resp(1);
        chk("rst_result1", s_res[1], 32'd8);

        // Random traffic against the reference model.
        for (int c = 0; c < 2500; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!rv[p] && $urandom_range(0, 3) == 0) begin
                    rx = $urandom;
                    ry = $urandom;
                    case ($urandom_range(0, 7))
                        0: ry = 32'd0;
                        1: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
                        2: ry = $urandom_range(1, 20);
                        default: ;
                    endcase
                    set_req(p, 2'($urandom_range(0, 3)), rx, ry, 5'($urandom));
                    wd[p] = 1'($urandom_range(0, 1));
                end
                rr[p] = ($urandom_range(0, 9) < 7);
                kl[p] = ($urandom_range(0, 49) == 0);
            end
            lat = $urandom_range(1, 6);
            force_busy = ($urandom_range(0, 19) == 0);
            cycle();
            for (int p = 0; p < 2; p++) if (s_rdy[p]) rv[p] = 1'b0;
        end
        rv = 2'b00; kl = 2'b00; rr = 2'b11; force_busy = 1'b0;
        for (int k = 0; k < 100 && m_out; k++) cycle();
        if (m_out) timeout("drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
